fp_wb_arbiter: RTL and testbench

FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

---
 rtl/fp_wb_arbiter_if.sv | 45 ++++
 rtl/fp_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_fp_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_wb_arbiter_if.sv
// Bundle of the FP writeback arbiter's issue, load, FPU and regfile-write
// signals. Names carry the _pi/_po suffixes as seen from the arbiter.
//
// Handshake: the FPU result port is valid/ready. A result transfers on a
// cycle where fpu_valid_pi && fpu_ready_po are both high at the posedge.
// While valid is high and ready is low, the producer keeps rd/data stable.
// The load port has valid only; a load result is always taken the cycle it
// is presented.
interface fp_wb_arbiter_if;
    logic        issue_valid_pi;
    logic [4:0]  issue_rd_pi;
    logic        ld_valid_pi;
    logic [4:0]  ld_rd_pi;
    logic [31:0] ld_data_pi;
    logic        fpu_valid_pi;
    logic [4:0]  fpu_rd_pi;
    logic [31:0] fpu_data_pi;
    logic        fpu_ready_po;
    logic        Fp_we_po;
    logic [4:0]  Fp_destReg_po;
    logic [31:0] Fp_writeData_po;
    logic [31:0] pending_po;
    logic [1:0]  fifo_count_po;

    // Pipeline side: drives issue, load and FPU results and observes the
    // arbiter.
    modport master (
        output issue_valid_pi, issue_rd_pi,
        output ld_valid_pi, ld_rd_pi, ld_data_pi,
        output fpu_valid_pi, fpu_rd_pi, fpu_data_pi,
        input  fpu_ready_po,
        input  Fp_we_po, Fp_destReg_po, Fp_writeData_po,
        input  pending_po, fifo_count_po
    );

    // Arbiter side.
    modport slave (
        input  issue_valid_pi, issue_rd_pi,
        input  ld_valid_pi, ld_rd_pi, ld_data_pi,
        input  fpu_valid_pi, fpu_rd_pi, fpu_data_pi,
        output fpu_ready_po,
        output Fp_we_po, Fp_destReg_po, Fp_writeData_po,
        output pending_po, fifo_count_po
    );
endinterface

// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter. Load results always win the write
// port. FPU results that lose arbitration wait in a 2-entry skid FIFO.
// A 32-bit pending scoreboard marks registers with a write still in flight.
module fp_wb_arbiter #(
    parameter int debug_param = 0
) (
    input logic         clk,
    input logic         reset,
    fp_wb_arbiter_if.slave bus
);

    logic [4:0]  fifo_rd   [2];
    logic [31:0] fifo_data [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fpu_ready;
    logic        fpu_accept;

    logic        win_valid;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    logic        pop;
    logic        push;
    logic        bypass;

    logic        we_q;
    logic [4:0]  dest_q;
    logic [31:0] data_q;
    logic [31:0] pending_q;
    logic [31:0] pending_next;

    // FIFO status and the FPU-side ready.
    always_comb begin
        fifo_full  = (fifo_count == 2'd2);
        fifo_empty = (fifo_count == 2'd0);
        fpu_ready  = !fifo_full && !reset;
        fpu_accept = bus.fpu_valid_pi && fpu_ready;
    end

    // Fixed-priority pick: load, then FIFO head, then bypass of this cycle's FPU result.
    always_comb begin
        win_valid = 1'b0;
        win_rd    = '0;
        win_data  = '0;
        pop       = 1'b0;
        bypass    = 1'b0;
        if (bus.ld_valid_pi) begin
            win_valid = 1'b1;
            win_rd    = bus.ld_rd_pi;
            win_data  = bus.ld_data_pi;
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win_rd    = fifo_rd[rd_ptr];
            win_data  = fifo_data[rd_ptr];
            pop       = 1'b1;
        end else if (fpu_accept) begin
            win_valid = 1'b1;
            win_rd    = bus.fpu_rd_pi;
            win_data  = bus.fpu_data_pi;
            bypass    = 1'b1;
        end
        // An accepted result that did not go straight through is parked.
        push = fpu_accept && !bypass;
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_rd[wr_ptr]   <= bus.fpu_rd_pi;
            fifo_data[wr_ptr] <= bus.fpu_data_pi;
        end
    end

    // Register the winner onto the regfile write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= win_valid;
            if (win_valid) begin
                dest_q <= win_rd;
                data_q <= win_data;
            end
        end
    end

    // Scoreboard update: clear the committing register, then set on issue so set wins.
    always_comb begin
        pending_next = pending_q;
        if (win_valid) begin
            pending_next[win_rd] = 1'b0;
        end
        if (bus.issue_valid_pi) begin
            pending_next[bus.issue_rd_pi] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_next;
        end
    end

    assign bus.fpu_ready_po    = fpu_ready;
    assign bus.Fp_we_po        = we_q;
    assign bus.Fp_destReg_po   = dest_q;
    assign bus.Fp_writeData_po = data_q;
    assign bus.pending_po      = pending_q;
    assign bus.fifo_count_po   = fifo_count;

    // Optional simulation trace of each committed write.
    generate
        if (debug_param != 0) begin : g_trace
            // Print one line per committed write, away from the update edge.
            always @(negedge clk) begin
                if (we_q) begin
                    $write("[fp_wb] rd=%0d data=%08h\n", dest_q, data_q);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter: a queue-based reference model checked
// every negedge, plus literal expectations for the described scenarios.
module tb_fp_wb_arbiter;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    fp_wb_arbiter_if bus ();

    fp_wb_arbiter #(.debug_param(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Writes waiting behind a load are kept as {rd, data} in arrival order.
    logic [36:0] exp_q[$];
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [31:0] exp_pending;
    bit          model_started;

    initial model_started = 1'b0;

    always @(posedge clk) begin
        bit          has_room;
        bit          fpu_taken;
        bit          commit;
        logic [4:0]  c_rd;
        logic [31:0] c_data;
        logic [36:0] head;
        model_started = 1'b1;
        if (reset) begin
            exp_we      = 1'b0;
            exp_rd      = '0;
            exp_data    = '0;
            exp_pending = '0;
            exp_q.delete();
        end else begin
            has_room  = (exp_q.size() < 2);
            fpu_taken = bus.fpu_valid_pi && has_room;
            commit    = 1'b0;
            c_rd      = '0;
            c_data    = '0;
            if (bus.ld_valid_pi) begin
                commit = 1'b1;
                c_rd   = bus.ld_rd_pi;
                c_data = bus.ld_data_pi;
            end else if (exp_q.size() > 0) begin
                head   = exp_q.pop_front();
                commit = 1'b1;
                c_rd   = head[36:32];
                c_data = head[31:0];
            end else if (fpu_taken) begin
                commit    = 1'b1;
                c_rd      = bus.fpu_rd_pi;
                c_data    = bus.fpu_data_pi;
                fpu_taken = 1'b0;
            end
            if (fpu_taken) begin
                exp_q.push_back({bus.fpu_rd_pi, bus.fpu_data_pi});
            end
            exp_we = commit;
            if (commit) begin
                exp_rd   = c_rd;
                exp_data = c_data;
                exp_pending[c_rd] = 1'b0;
            end
            if (bus.issue_valid_pi) begin
                exp_pending[bus.issue_rd_pi] = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_started) begin
            check("m_we",      {31'd0, bus.Fp_we_po},      {31'd0, exp_we});
            check("m_rd",      {27'd0, bus.Fp_destReg_po}, {27'd0, exp_rd});
            check("m_data",    bus.Fp_writeData_po,        exp_data);
            check("m_pending", bus.pending_po,             exp_pending);
            check("m_count",   {30'd0, bus.fifo_count_po}, 32'(exp_q.size()));
            check("m_ready",   {31'd0, bus.fpu_ready_po},
                  {31'd0, (exp_q.size() != 2) && !reset});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit iv, input logic [4:0] ird,
                          input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                          input bit fv, input logic [4:0] frd, input logic [31:0] fdat);
        bus.issue_valid_pi = iv;
        bus.issue_rd_pi    = ird;
        bus.ld_valid_pi    = lv;
        bus.ld_rd_pi       = lrd;
        bus.ld_data_pi     = ldat;
        bus.fpu_valid_pi   = fv;
        bus.fpu_rd_pi      = frd;
        bus.fpu_data_pi    = fdat;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_wr(input string name, input bit we, input logic [4:0] rd,
                             input logic [31:0] data);
        check({name, "_we"}, {31'd0, bus.Fp_we_po}, {31'd0, we});
        check({name, "_rd"}, {27'd0, bus.Fp_destReg_po}, {27'd0, rd});
        check({name, "_data"}, bus.Fp_writeData_po, data);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        idle();
        step();
        step();
        expect_wr("rst", 0, 5'd0, 32'h0);
        check("rst_pending", bus.pending_po, 32'h0);
        check("rst_count", {30'd0, bus.fifo_count_po}, 32'd0);
        check("rst_ready", {31'd0, bus.fpu_ready_po}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, bus.fpu_ready_po}, 32'd1);

        // Load only.
        set_in(0, 0, 1, 5'd5, 32'h3F80_0000, 0, 0, 0);
        step();
        expect_wr("ld_only", 1, 5'd5, 32'h3F80_0000);
        idle();
        step();
        expect_wr("ld_only_after", 0, 5'd5, 32'h3F80_0000);

        // Load and FPU collide.
        set_in(0, 0, 1, 5'd2, 32'h11, 1, 5'd3, 32'h22);
        step();
        expect_wr("conf_c1", 1, 5'd2, 32'h11);
        check("conf_c1_count", {30'd0, bus.fifo_count_po}, 32'd1);
        idle();
        step();
        expect_wr("conf_c2", 1, 5'd3, 32'h22);
        check("conf_c2_count", {30'd0, bus.fifo_count_po}, 32'd0);
        step();

        // FIFO fills behind four loads.
        set_in(0, 0, 1, 5'd10, 32'h100, 1, 5'd20, 32'h200);
        step();
        set_in(0, 0, 1, 5'd11, 32'h101, 1, 5'd21, 32'h201);
        step();
        expect_wr("full_c2", 1, 5'd11, 32'h101);
        check("full_c2_count", {30'd0, bus.fifo_count_po}, 32'd2);
        check("full_c2_ready", {31'd0, bus.fpu_ready_po}, 32'd0);
        set_in(0, 0, 1, 5'd12, 32'h102, 1, 5'd22, 32'h202);
        step();
        set_in(0, 0, 1, 5'd13, 32'h103, 1, 5'd22, 32'h202);
        step();
        expect_wr("full_c4", 1, 5'd13, 32'h103);
        check("full_c4_count", {30'd0, bus.fifo_count_po}, 32'd2);
        set_in(0, 0, 0, 0, 0, 1, 5'd22, 32'h202);
        step();
        expect_wr("drain_a", 1, 5'd20, 32'h200);
        check("drain_a_count", {30'd0, bus.fifo_count_po}, 32'd1);
        step();
        expect_wr("drain_b", 1, 5'd21, 32'h201);
        check("drain_b_count", {30'd0, bus.fifo_count_po}, 32'd1);
        idle();
        step();
        expect_wr("drain_c", 1, 5'd22, 32'h202);
        check("drain_c_count", {30'd0, bus.fifo_count_po}, 32'd0);
        set_in(0, 0, 0, 0, 0, 1, 5'd23, 32'h203);
        step();
        expect_wr("bypass", 1, 5'd23, 32'h203);
        check("bypass_count", {30'd0, bus.fifo_count_po}, 32'd0);
        idle();
        step();

        // Scoreboard.
        set_in(1, 5'd7, 0, 0, 0, 0, 0, 0);
        step();
        check("sb_set", bus.pending_po, 32'h0000_0080);
        set_in(0, 0, 0, 0, 0, 1, 5'd7, 32'h77);
        step();
        expect_wr("sb_commit", 1, 5'd7, 32'h77);
        check("sb_clear", bus.pending_po, 32'h0);
        set_in(1, 5'd7, 0, 0, 0, 0, 0, 0);
        step();
        set_in(1, 5'd7, 0, 0, 0, 1, 5'd7, 32'h78);
        step();
        expect_wr("sb_both", 1, 5'd7, 32'h78);
        check("sb_set_wins", bus.pending_po, 32'h0000_0080);
        set_in(0, 0, 0, 0, 0, 1, 5'd7, 32'h79);
        step();
        check("sb_clear2", bus.pending_po, 32'h0);

        // Register 0 is a normal destination.
        set_in(1, 5'd0, 0, 0, 0, 0, 0, 0);
        step();
        check("r0_pending", bus.pending_po, 32'h1);
        set_in(0, 0, 0, 0, 0, 1, 5'd0, 32'hABCD);
        step();
        expect_wr("r0_commit", 1, 5'd0, 32'hABCD);
        check("r0_clear", bus.pending_po, 32'h0);

        // Reset with a full FIFO and pending bits.
        set_in(1, 5'd2, 0, 0, 0, 0, 0, 0);
        step();
        set_in(1, 5'd7, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 1, 5'd1, 32'h31, 1, 5'd2, 32'h42);
        step();
        set_in(0, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        step();
        check("pre_rst_count", {30'd0, bus.fifo_count_po}, 32'd2);
        check("pre_rst_pending", bus.pending_po, 32'h0000_0084);
        reset = 1'b1;
        set_in(1, 5'd5, 1, 5'd9, 32'h99, 1, 5'd4, 32'h44);
        step();
        expect_wr("mid_rst", 0, 5'd0, 32'h0);
        check("mid_rst_pending", bus.pending_po, 32'h0);
        check("mid_rst_count", {30'd0, bus.fifo_count_po}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.fpu_ready_po}, 32'd0);
        reset = 1'b0;
        idle();
        #1;
        check("post_rst_ready", {31'd0, bus.fpu_ready_po}, 32'd1);
        step();
        expect_wr("post_rst", 0, 5'd0, 32'h0);
        check("post_rst_count", {30'd0, bus.fifo_count_po}, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
